// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding imem requests, 2-entry {inst, pc} buffer,
// valid/ready hand-off to decode, and redirect-driven flush of everything in flight.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_DROP  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] req_pc_q;
  logic [31:0] inst0_q, inst1_q;
  logic [31:0] ipc0_q, ipc1_q;
  logic        issue, push, pop;

  assign imem_req   = !reset && (state_q == S_FETCH) && (count_q < 2'd2) && !redirect_valid;
  assign imem_addr  = pc_q;
  assign issue      = imem_req && imem_gnt;
  assign push       = (state_q == S_WAIT) && imem_rvalid && !redirect_valid;
  assign inst_valid = !reset && (count_q != 2'd0);
  assign pop        = inst_valid && inst_ready && !redirect_valid;

  assign inst    = inst_valid ? inst0_q : NOP_INST;
  assign inst_pc = inst_valid ? ipc0_q  : 32'h0000_0000;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    if (redirect_valid) begin
      pc_d    = {redirect_pc[31:2], 2'b00};
      count_d = 2'd0;
      // An in-flight request whose response has not yet arrived must be absorbed later.
      if ((state_q == S_WAIT || state_q == S_DROP) && !imem_rvalid)
        state_d = S_DROP;
      else
        state_d = S_FETCH;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (issue) begin
            pc_d    = pc_q + 32'd4;
            state_d = S_WAIT;
          end
        end
        S_WAIT, S_DROP: begin
          if (imem_rvalid) state_d = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      count_q <= 2'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  // Buffer storage is head-at-slot-0; occupancy lives in count_q, so data needs no reset.
  always_ff @(posedge clk) begin
    if (issue) req_pc_q <= pc_q;
    if (pop) begin
      inst0_q <= inst1_q;
      ipc0_q  <= ipc1_q;
    end
    if (push) begin
      if (count_q == 2'd0 || (count_q == 2'd1 && pop)) begin
        inst0_q <= imem_rdata;
        ipc0_q  <= req_pc_q;
      end else begin
        inst1_q <= imem_rdata;
        ipc1_q  <= req_pc_q;
      end
    end
  end

endmodule
